// File: rtl/flash_pkg.sv
// Shared definitions for the flash macro executors: macro codes, opcodes,
// default geometry/timing and the page-program state encoding.
package flash_pkg;

    localparam logic [3:0] MACRO_FLASH_WR_PG = 4'hC;

    localparam logic [7:0] CMD_WREN  = 8'h06;
    localparam logic [7:0] CMD_PP    = 8'h02;
    localparam logic [7:0] CMD_RDSR  = 8'h05;
    localparam logic [7:0] CMD_DUMMY = 8'h00;

    localparam int unsigned PG_BYTES     = 256;
    localparam int unsigned CS_GAP_CYC   = 4;
    localparam logic [31:0] POLL_TIMEOUT = 32'd50_000_000;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WREN_CS,
        ST_WREN_XFER,
        ST_WREN_END,
        ST_PP_HDR,
        ST_PP_DATA,
        ST_PP_END,
        ST_POLL,
        ST_POLL_END,
        ST_DONE
    } flash_state_e;

    // Page-program header: opcode followed by the 24-bit address, MSB first.
    function automatic logic [7:0] pp_hdr_byte(input logic [1:0] idx, input logic [23:0] addr);
        case (idx)
            2'd0:    return CMD_PP;
            2'd1:    return addr[23:16];
            2'd2:    return addr[15:8];
            default: return addr[7:0];
        endcase
    endfunction

endpackage

// File: rtl/flash_page_prog_ctrl_if.sv
// Programming-FIFO and QSPI byte-shifter signals seen by the page-program controller.
interface flash_page_prog_ctrl_if;
    logic [7:0] fifo_dout;
    logic       fifo_empty;
    logic       fifo_rd_en;
    logic       spi_cs_n;
    logic [7:0] spi_tx_byte;
    logic       spi_go;
    logic       spi_done;
    logic [7:0] spi_rx_byte;

    modport master (
        input  fifo_dout, fifo_empty, spi_done, spi_rx_byte,
        output fifo_rd_en, spi_cs_n, spi_tx_byte, spi_go
    );

    modport slave (
        output fifo_dout, fifo_empty, spi_done, spi_rx_byte,
        input  fifo_rd_en, spi_cs_n, spi_tx_byte, spi_go
    );
endinterface

// File: rtl/flash_cs_gap_timer.sv
// Chip-select deselect timer: load starts a GAP_CYC-cycle window, expired
// is high in the last cycle of that window and stays high until the next load.
module flash_cs_gap_timer
    import flash_pkg::*;
#(
    parameter int unsigned GAP_CYC = CS_GAP_CYC
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic expired
);

    localparam int unsigned W = $clog2(GAP_CYC + 1);

    logic [W-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= W'(GAP_CYC - 1);
        end else if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - 1'b1;
        end
    end

    assign expired = (cnt_reg == '0);

endmodule

// File: rtl/flash_page_prog_ctrl.sv
// FlashWrPg macro executor: WREN, page program from the programming FIFO,
// then RDSR polling until WIP clears or the poll budget runs out.
module flash_page_prog_ctrl #(
    parameter int unsigned PG_BYTES     = flash_pkg::PG_BYTES,
    parameter int unsigned CS_GAP_CYC   = flash_pkg::CS_GAP_CYC,
    parameter logic [31:0] POLL_TIMEOUT = flash_pkg::POLL_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  macro_states,
    input  logic        macro_states_valid,
    input  logic [31:0] addr_reg,
    output logic        flash_macro_states_done,
    output logic        flash_err,
    output logic        busy,
    flash_page_prog_ctrl_if.master bus
);

    import flash_pkg::*;

    flash_state_e state_reg, state_next;
    logic [8:0]   byte_cnt_reg, byte_cnt_next;
    logic [31:0]  poll_cnt_reg, poll_cnt_next;
    logic [23:0]  addr_lat_reg, addr_lat_next;
    logic         pend_reg, pend_next;
    logic         wip_reg, wip_next;
    logic         err_reg, err_next;
    logic         gap_load;
    logic         gap_expired;
    logic         xfer_done;
    logic         unused_ok;

    assign unused_ok = ^{addr_reg[31:24], bus.spi_rx_byte[7:1]};

    // A shifter completion only counts while this block has a byte in flight.
    assign xfer_done = pend_reg && bus.spi_done;

    flash_cs_gap_timer #(.GAP_CYC(CS_GAP_CYC)) u_gap_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (gap_load),
        .expired (gap_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            byte_cnt_reg <= '0;
            poll_cnt_reg <= '0;
            addr_lat_reg <= '0;
            pend_reg     <= 1'b0;
            wip_reg      <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            byte_cnt_reg <= byte_cnt_next;
            poll_cnt_reg <= poll_cnt_next;
            addr_lat_reg <= addr_lat_next;
            pend_reg     <= pend_next;
            wip_reg      <= wip_next;
            err_reg      <= err_next;
        end
    end

    always_comb begin
        state_next              = state_reg;
        byte_cnt_next           = byte_cnt_reg;
        poll_cnt_next           = poll_cnt_reg;
        addr_lat_next           = addr_lat_reg;
        pend_next               = pend_reg;
        wip_next                = wip_reg;
        err_next                = err_reg;
        gap_load                = 1'b0;
        bus.spi_cs_n            = 1'b1;
        bus.spi_go              = 1'b0;
        bus.spi_tx_byte         = 8'h00;
        bus.fifo_rd_en          = 1'b0;
        flash_macro_states_done = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (macro_states_valid && macro_states == MACRO_FLASH_WR_PG) begin
                    addr_lat_next = addr_reg[23:0];
                    err_next      = 1'b0;
                    poll_cnt_next = '0;
                    byte_cnt_next = '0;
                    state_next    = ST_WREN_CS;
                end
            end
            ST_WREN_CS: begin
                bus.spi_cs_n = 1'b0;
                state_next   = ST_WREN_XFER;
            end
            ST_WREN_XFER: begin
                bus.spi_cs_n    = 1'b0;
                bus.spi_tx_byte = CMD_WREN;
                if (!pend_reg) begin
                    bus.spi_go = 1'b1;
                    pend_next  = 1'b1;
                end else if (xfer_done) begin
                    pend_next  = 1'b0;
                    gap_load   = 1'b1;
                    state_next = ST_WREN_END;
                end
            end
            ST_WREN_END: begin
                if (gap_expired) state_next = ST_PP_HDR;
            end
            ST_PP_HDR: begin
                bus.spi_cs_n    = 1'b0;
                bus.spi_tx_byte = pp_hdr_byte(byte_cnt_reg[1:0], addr_lat_reg);
                if (!pend_reg) begin
                    bus.spi_go = 1'b1;
                    pend_next  = 1'b1;
                end else if (xfer_done) begin
                    pend_next = 1'b0;
                    if (byte_cnt_reg == 9'd3) begin
                        byte_cnt_next = '0;
                        state_next    = ST_PP_DATA;
                    end else begin
                        byte_cnt_next = byte_cnt_reg + 9'd1;
                    end
                end
            end
            ST_PP_DATA: begin
                // An empty FIFO simply holds here with CS still asserted.
                bus.spi_cs_n    = 1'b0;
                bus.spi_tx_byte = bus.fifo_dout;
                if (!pend_reg && !bus.fifo_empty) begin
                    bus.spi_go     = 1'b1;
                    bus.fifo_rd_en = 1'b1;
                    pend_next      = 1'b1;
                end else if (xfer_done) begin
                    pend_next = 1'b0;
                    if (byte_cnt_reg == 9'(PG_BYTES - 1)) begin
                        byte_cnt_next = '0;
                        gap_load      = 1'b1;
                        state_next    = ST_PP_END;
                    end else begin
                        byte_cnt_next = byte_cnt_reg + 9'd1;
                    end
                end
            end
            ST_PP_END: begin
                if (gap_expired) state_next = ST_POLL;
            end
            ST_POLL: begin
                bus.spi_cs_n    = 1'b0;
                bus.spi_tx_byte = byte_cnt_reg[0] ? CMD_DUMMY : CMD_RDSR;
                if (!pend_reg) begin
                    bus.spi_go = 1'b1;
                    pend_next  = 1'b1;
                end else if (xfer_done) begin
                    pend_next = 1'b0;
                    if (byte_cnt_reg[0]) begin
                        wip_next      = bus.spi_rx_byte[0];
                        byte_cnt_next = '0;
                        gap_load      = 1'b1;
                        state_next    = ST_POLL_END;
                    end else begin
                        byte_cnt_next = 9'd1;
                    end
                end
            end
            ST_POLL_END: begin
                if (gap_expired) begin
                    if (!wip_reg) begin
                        state_next = ST_DONE;
                    end else if (poll_cnt_reg == POLL_TIMEOUT - 32'd1) begin
                        err_next   = 1'b1;
                        state_next = ST_DONE;
                    end else begin
                        poll_cnt_next = poll_cnt_reg + 32'd1;
                        state_next    = ST_POLL;
                    end
                end
            end
            ST_DONE: begin
                flash_macro_states_done = 1'b1;
                state_next              = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign busy      = (state_reg != ST_IDLE) && (state_reg != ST_DONE);
    assign flash_err = err_reg;

endmodule

// File: tb/tb_flash_page_prog_ctrl.sv
// Scoreboard bench for flash_page_prog_ctrl with a FIFO model and a byte-shifter/flash-status model.
module tb_flash_page_prog_ctrl;
    import flash_pkg::*;

    localparam int unsigned PG  = 256;
    localparam int unsigned GAP = 4;
    localparam logic [31:0] TMO = 32'd5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  macro_states = 4'h0;
    logic        macro_states_valid = 1'b0;
    logic [31:0] addr_reg = 32'h0;
    logic        flash_macro_states_done;
    logic        flash_err;
    logic        busy;

    flash_page_prog_ctrl_if bus();

    flash_page_prog_ctrl #(.PG_BYTES(PG), .CS_GAP_CYC(GAP), .POLL_TIMEOUT(TMO)) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .macro_states            (macro_states),
        .macro_states_valid      (macro_states_valid),
        .addr_reg                (addr_reg),
        .flash_macro_states_done (flash_macro_states_done),
        .flash_err               (flash_err),
        .busy                    (busy),
        .bus                     (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // FIFO model (first-word-fall-through)
    logic [7:0] fifo_mem [0:1023];
    int  wr_ptr = 0;
    int  rd_ptr = 0;
    bit  flush_req = 1'b0;
    assign bus.fifo_empty = (rd_ptr == wr_ptr);
    assign bus.fifo_dout  = fifo_mem[rd_ptr[9:0]];

    // Shifter / flash status model
    int         sh_cnt = 0;
    logic       model_done = 1'b0;
    logic [7:0] model_rx = 8'h00;
    bit         spur_done = 1'b0;
    int         win_idx = 0;
    logic [7:0] win_first = 8'h00;
    int         polls_total = 0;
    int         wip_until = 0;
    assign bus.spi_done    = model_done | spur_done;
    assign bus.spi_rx_byte = model_rx;

    // Samples taken at negedge, acted on by the models at the following posedge
    logic       s_go, s_rd, s_cs, s_empty, s_done, s_busy, s_err;
    logic [7:0] s_tx;

    always @(posedge clk) begin
        if (flush_req) rd_ptr <= wr_ptr;
        else if (s_rd === 1'b1 && !s_empty) rd_ptr <= rd_ptr + 1;
        model_done <= (sh_cnt == 1);
        if (s_go === 1'b1) begin
            sh_cnt <= 3;
            if (win_idx == 1 && win_first == CMD_RDSR) begin
                model_rx    <= (polls_total < wip_until) ? 8'h01 : 8'hFE;
                polls_total <= polls_total + 1;
            end else begin
                model_rx <= 8'hFF;
            end
        end else if (sh_cnt > 0) begin
            sh_cnt <= sh_cnt - 1;
        end
        if (s_cs === 1'b1) win_idx <= 0;
        else if (s_go === 1'b1) begin
            if (win_idx == 0) win_first <= s_tx;
            win_idx <= win_idx + 1;
        end
    end

    // Scoreboard queues and monitor
    logic [7:0] exp_bytes[$];
    int         exp_len[$];
    bit         exp_done[$];
    int   cyc = 0;
    logic prev_cs = 1'b1;
    int   win_bytes = 0;
    int   high_len = 0;
    int   last_sd_cyc = 0;
    int   pops = 0;

    always @(negedge clk) begin
        cyc++;
        s_go = bus.spi_go; s_rd = bus.fifo_rd_en; s_cs = bus.spi_cs_n; s_tx = bus.spi_tx_byte;
        s_empty = bus.fifo_empty; s_done = flash_macro_states_done; s_busy = busy; s_err = flash_err;
        if (prev_cs === 1'b1 && s_cs === 1'b0) begin
            check("cs_gap_ge_min", 32'(high_len >= int'(GAP)), 32'd1);
            win_bytes = 0;
        end
        if (s_rd === 1'b1) begin
            check("pop_fifo_nonempty", 32'(s_empty), 32'd0);
            check("pop_with_go", 32'(s_go), 32'd1);
            pops++;
        end
        if (s_go === 1'b1) begin
            check("go_cs_low", 32'(s_cs), 32'd0);
            check("go_shifter_idle", 32'(sh_cnt != 0 || model_done), 32'd0);
            if (exp_bytes.size() == 0) check("unexpected_go_byte", 32'(s_tx), 32'h100);
            else check("tx_byte", 32'(s_tx), 32'(exp_bytes.pop_front()));
            win_bytes++;
        end
        if (model_done === 1'b1) last_sd_cyc = cyc;
        if (prev_cs === 1'b0 && s_cs === 1'b1) begin
            if (exp_len.size() == 0) check("unexpected_xfer_len", 32'(win_bytes), 32'hFFFF);
            else check("xfer_len", 32'(win_bytes), 32'(exp_len.pop_front()));
            high_len = 1;
        end else if (s_cs === 1'b1) begin
            high_len++;
        end
        prev_cs = s_cs;
        if (s_done === 1'b1) begin
            if (exp_done.size() == 0) check("unexpected_done", 32'd1, 32'd0);
            else check("done_err", 32'(s_err), 32'(exp_done.pop_front()));
            check("done_busy_low", 32'(s_busy), 32'd0);
            check("done_latency", 32'(cyc - last_sd_cyc), 32'(GAP + 1));
        end
    end

    task automatic fifo_push(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            fifo_mem[wr_ptr[9:0]] = 8'(base + i);
            wr_ptr = wr_ptr + 1;
        end
    endtask

    task automatic expect_prog(input logic [23:0] a, input int base, input int ndata,
                               input int npolls, input bit err, input bit with_done);
        exp_bytes.push_back(CMD_WREN);
        exp_len.push_back(1);
        exp_bytes.push_back(CMD_PP);
        exp_bytes.push_back(a[23:16]);
        exp_bytes.push_back(a[15:8]);
        exp_bytes.push_back(a[7:0]);
        for (int i = 0; i < ndata; i++) exp_bytes.push_back(8'(base + i));
        exp_len.push_back(4 + ndata);
        for (int p = 0; p < npolls; p++) begin
            exp_bytes.push_back(CMD_RDSR);
            exp_bytes.push_back(8'h00);
            exp_len.push_back(2);
        end
        if (with_done) exp_done.push_back(err);
    endtask

    task automatic strobe(input logic [3:0] code, input logic [31:0] addr);
        @(posedge clk); #1;
        macro_states = code; addr_reg = addr; macro_states_valid = 1'b1;
        @(posedge clk); #1;
        macro_states_valid = 1'b0;
    endtask

    task automatic start_prog(input logic [31:0] addr);
        strobe(MACRO_FLASH_WR_PG, addr);
        check("accept_busy", 32'(busy), 32'd1);
        check("accept_err_clear", 32'(flash_err), 32'd0);
        check("accept_cs_low_no_go", 32'({bus.spi_cs_n, bus.spi_go}), 32'd0);
        @(posedge clk); #1;
        check("first_go_latency", 32'(bus.spi_go), 32'd1);
    endtask

    task automatic wait_idle(input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            @(negedge clk);
            if (exp_done.size() == 0 && busy === 1'b0) break;
        end
        if (k >= budget) check("done_timeout", 32'(exp_done.size()), 32'd0);
        repeat (20) @(negedge clk);
        check("exp_bytes_drained", 32'(exp_bytes.size()), 32'd0);
        check("exp_xfers_drained", 32'(exp_len.size()), 32'd0);
    endtask

    task automatic wait_pops(input int p0, input int n);
        for (int k = 0; k < 5000 && (pops - p0) < n; k++) @(negedge clk);
        check("reach_pop_count", 32'((pops - p0) >= n), 32'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int p0;
        repeat (3) @(posedge clk); #1;
        check("rst_cs_n", 32'(bus.spi_cs_n), 32'd1);
        check("rst_outputs", 32'({busy, flash_err, flash_macro_states_done, bus.spi_go, bus.fifo_rd_en}), 32'd0);
        check("rst_tx_byte", 32'(bus.spi_tx_byte), 32'd0);
        rst_n = 1'b1;

        // Spurious shifter completion while idle must do nothing
        @(posedge clk); #1; spur_done = 1'b1;
        @(posedge clk); #1; spur_done = 1'b0;
        repeat (10) @(negedge clk);
        check("spur_idle_busy", 32'({busy, bus.spi_cs_n}), 32'd1);

        // Normal program, WIP high for 3 polls
        p0 = pops;
        fifo_push(256, 0);
        wip_until = polls_total + 3;
        expect_prog(24'h012300, 0, 256, 4, 1'b0, 1'b1);
        start_prog(32'h0001_2300);
        wait_idle(5000);
        check("normal_pop_count", 32'(pops - p0), 32'd256);

        // Foreign macro code ignored
        strobe(4'hD, 32'h0000_4400);
        repeat (30) @(negedge clk);
        check("ignore_code_busy", 32'(busy), 32'd0);
        check("ignore_code_cs", 32'(bus.spi_cs_n), 32'd1);

        // Second strobe mid-page ignored; upper address byte dropped, unaligned low byte kept
        p0 = pops;
        fifo_push(256, 8'h80);
        wip_until = polls_total;
        expect_prog(24'hABCD05, 8'h80, 256, 1, 1'b0, 1'b1);
        start_prog(32'hFFAB_CD05);
        wait_pops(p0, 50);
        strobe(MACRO_FLASH_WR_PG, 32'h0000_1000);
        wait_idle(5000);
        check("midpage_pop_count", 32'(pops - p0), 32'd256);

        // Poll timeout: WIP stuck high
        fifo_push(256, 8'h33);
        wip_until = polls_total + 1000;
        expect_prog(24'h040000, 8'h33, 256, 5, 1'b1, 1'b1);
        start_prog(32'h0004_0000);
        wait_idle(5000);
        check("timeout_err_sticky", 32'(flash_err), 32'd1);

        // Next command clears the error
        fifo_push(256, 8'hE7);
        wip_until = polls_total + 2;
        expect_prog(24'h050000, 8'hE7, 256, 3, 1'b0, 1'b1);
        start_prog(32'h0005_0000);
        wait_idle(5000);
        check("post_timeout_err", 32'(flash_err), 32'd0);

        // FIFO starvation mid-page
        p0 = pops;
        fifo_push(10, 8'h10);
        wip_until = polls_total;
        expect_prog(24'h000100, 8'h10, 256, 1, 1'b0, 1'b1);
        start_prog(32'h0000_0100);
        repeat (500) @(negedge clk);
        check("starve_cs_low", 32'(bus.spi_cs_n), 32'd0);
        check("starve_busy", 32'(busy), 32'd1);
        check("starve_pops", 32'(pops - p0), 32'd10);
        fifo_push(246, 8'h1A);
        wait_idle(5000);

        // Reset after 100 data bytes
        p0 = pops;
        fifo_push(256, 8'hC0);
        expect_prog(24'h020000, 8'hC0, 100, 0, 1'b0, 1'b0);
        start_prog(32'h0002_0000);
        wait_pops(p0, 100);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_cs_n", 32'(bus.spi_cs_n), 32'd1);
        check("async_rst_busy_done", 32'({busy, flash_macro_states_done}), 32'd0);
        repeat (3) @(posedge clk); #1;
        rst_n = 1'b1;
        flush_req = 1'b1;
        @(posedge clk); #1;
        flush_req = 1'b0;
        repeat (20) @(negedge clk);
        check("post_rst_idle", 32'({busy, bus.spi_cs_n}), 32'd1);

        // Clean run after reset
        p0 = pops;
        fifo_push(256, 8'h5A);
        wip_until = polls_total + 1;
        expect_prog(24'h00FF00, 8'h5A, 256, 2, 1'b0, 1'b1);
        start_prog(32'h0000_FF00);
        wait_idle(5000);
        check("post_rst_pop_count", 32'(pops - p0), 32'd256);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
